// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - ALU with single-cycle ops and iterative shift-add multiply
module alu_multicycle #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SRAV = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_BNE  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             alu_ill;
    logic [WIDTH-1:0] acc_next;
    logic             mul_last;

    // Single-cycle operation result, decoded straight from the request inputs
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (ctrl_i)
            OP_ADD:  alu_res = src1_i + src2_i;
            OP_SUB:  alu_res = src1_i - src2_i;
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SRA:  alu_res = $unsigned($signed(src2_i) >>> shamt_i);
            OP_SRAV: alu_res = $unsigned($signed(src2_i) >>> src1_i[SHW-1:0]);
            OP_BNE:  alu_res = src1_i - src2_i;
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
        // BNE inverts the sense of the flag: set means branch taken
        if (alu_ill)
            alu_zero = 1'b0;
        else if (ctrl_i == OP_BNE)
            alu_zero = |alu_res;
        else
            alu_zero = ~|alu_res;
    end

    // One shift-add step; the last step's sum feeds the result register directly
    always_comb begin
        acc_next = mplier[0] ? (acc + mcand) : acc;
        mul_last = (cnt == SHW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; start is only honoured in IDLE, with no queuing
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start_i)
                    next_state = (ctrl_i == OP_MUL) ? S_MUL : S_DONE;
            end
            S_MUL: begin
                if (mul_last)
                    next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture, multiply iterations and result/flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            result_o  <= '0;
            zero_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (ctrl_i == OP_MUL) begin
                            mcand  <= src1_i;
                            mplier <= src2_i;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            result_o  <= alu_res;
                            zero_o    <= alu_zero;
                            illegal_o <= alu_ill;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (mul_last) begin
                        result_o  <= acc_next;
                        zero_o    <= ~|acc_next;
                        illegal_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs follow the state directly
    always_comb begin
        busy_o = (state == S_MUL);
        done_o = (state == S_DONE);
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle
module tb_alu_multicycle;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SRA  = 4'b1000;
    localparam logic [3:0] C_SRAV = 4'b1001;
    localparam logic [3:0] C_MUL  = 4'b1011;
    localparam logic [3:0] C_BNE  = 4'b1100;
    localparam logic [3:0] C_BAD  = 4'b0101;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  shamt_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;
    logic        illegal_o;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic        z;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .ctrl_i    (ctrl_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .shamt_i   (shamt_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .illegal_o (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst_i && done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, ".result"},  result_o,           e.res);
                chk({e.nm, ".zero"},    {31'd0, zero_o},    {31'd0, e.z});
                chk({e.nm, ".illegal"}, {31'd0, illegal_o}, {31'd0, e.ill});
            end
        end
    end

    task automatic issue(input string nm, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] er, input logic ez, input logic ei,
                         input bit push);
        exp_t e;
        @(negedge clk);
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        shamt_i = sh;
        start_i = 1'b1;
        if (push) begin
            e.nm = nm; e.res = er; e.z = ez; e.ill = ei;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        src1_i  = $urandom;
        src2_i  = $urandom;
        shamt_i = 5'($urandom);
    endtask

    task automatic wait_done(input string nm, input int lat);
        int n  = 0;
        int nb = 0;
        bit seen = 0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            if (done_o) seen = 1;
            else if (busy_o) nb++;
        end
        chk({nm, ".latency"}, seen ? 32'(n) : 32'hDEAD_0000, 32'(lat));
        chk({nm, ".busy_cycles"}, 32'(nb), 32'(lat - 1));
    endtask

    task automatic op(input string nm, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh,
                      input logic [31:0] er, input logic ez, input logic ei, input int lat);
        issue(nm, c, a, b, sh, er, ez, ei, 1'b1);
        wait_done(nm, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; ctrl_i = '0;
        src1_i = '0; src2_i = '0; shamt_i = '0;
        repeat (3) @(negedge clk);
        chk("reset.done",    {31'd0, done_o},    32'd0);
        chk("reset.busy",    {31'd0, busy_o},    32'd0);
        chk("reset.result",  result_o,           32'd0);
        chk("reset.zero",    {31'd0, zero_o},    32'd0);
        chk("reset.illegal", {31'd0, illegal_o}, 32'd0);
        rst_i = 1'b0;

        op("add_5_3", C_ADD, 32'd5, 32'd3, 5'd0, 32'd8, 1'b0, 1'b0, 1);

        // Abandoned multiply: reset in its tenth cycle, no done for it
        issue("mul_abort", C_MUL, 32'd7, 32'd9, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        #1 rst_i = 1'b1;
        #1;
        chk("abort.busy",   {31'd0, busy_o}, 32'd0);
        chk("abort.done",   {31'd0, done_o}, 32'd0);
        chk("abort.result", result_o,        32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (40) @(negedge clk);
        op("add_after_abort", C_ADD, 32'd5, 32'd3, 5'd0, 32'd8, 1'b0, 1'b0, 1);

        op("sub_zero",  C_SUB, 32'h10, 32'h10, 5'd0, 32'h0,        1'b1, 1'b0, 1);
        op("bne_eq",    C_BNE, 32'd4,  32'd4,  5'd0, 32'h0,        1'b0, 1'b0, 1);
        op("bne_ne",    C_BNE, 32'd4,  32'd5,  5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1);
        op("add_wrap",  C_ADD, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h0,   1'b1, 1'b0, 1);
        op("or",        C_OR,  32'hF0, 32'h0F, 5'd0, 32'hFF,       1'b0, 1'b0, 1);
        op("slt_neg",   C_SLT, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1,   1'b0, 1'b0, 1);
        op("slt_pos",   C_SLT, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0,   1'b1, 1'b0, 1);
        op("sra",       C_SRA, 32'd0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, 1'b0, 1);
        op("srav",      C_SRAV, 32'h24, 32'h80000000, 5'd0, 32'hF8000000, 1'b0, 1'b0, 1);

        op("mul_ffff",  C_MUL, 32'h0000FFFF, 32'h0000FFFF, 5'd0, 32'hFFFE0001, 1'b0, 1'b0, 33);
        op("mul_neg1",  C_MUL, 32'hFFFFFFFF, 32'd3, 5'd0, 32'hFFFFFFFD, 1'b0, 1'b0, 33);
        op("mul_zero",  C_MUL, 32'd0, 32'h12345678, 5'd0, 32'd0, 1'b1, 1'b0, 33);

        // Start pulsed every cycle: only every second request lands in IDLE
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ctrl_i = C_ADD; src1_i = 32'(i); src2_i = 32'd10; start_i = 1'b1;
            if (i % 2 == 0) begin
                exp_t e;
                e.nm = $sformatf("burst%0d", i); e.res = 32'(i + 10); e.z = 1'b0; e.ill = 1'b0;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("burst.drained", 32'(sb.size()), 32'd0);

        // Start held through a multiply: one result only
        begin
            exp_t e;
            @(negedge clk);
            ctrl_i = C_MUL; src1_i = 32'd6; src2_i = 32'd7; start_i = 1'b1;
            e.nm = "mul_held"; e.res = 32'd42; e.z = 1'b0; e.ill = 1'b0;
            sb.push_back(e);
            repeat (5) @(negedge clk);
            start_i = 1'b0;
            wait_done("mul_held", 28);
        end

        op("illegal",   C_BAD, 32'h1234, 32'h5678, 5'd0, 32'd0, 1'b0, 1'b1, 1);
        op("and_after", C_AND, 32'hF0F0, 32'hFF00, 5'd0, 32'hF000, 1'b0, 1'b0, 1);

        repeat (4) @(negedge clk);
        chk("scoreboard.empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Execution-side consumer of the 4-bit ALU control code produced by the ALU controller.
- Performs the operation selected by the code on two registered operands.
- Single-cycle ops complete one cycle after start; MUL runs as an iterative shift-add sequence.
- Start/busy/done handshake lets the pipeline control stall during long operations.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, >= 8.
- SHW, log2(WIDTH) (localparam, derived), shift-amount width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- start_i  input  1  request strobe; sampled only in IDLE.
- ctrl_i  input  4  ALU control code; sampled with start_i.
- src1_i  input  WIDTH  operand A; sampled with start_i.
- src2_i  input  WIDTH  operand B; sampled with start_i.
- shamt_i  input  SHW  shift amount for SRA; sampled with start_i.
- busy_o  output  1  high while an operation is in progress (MUL state).
- done_o  output  1  one-cycle pulse: result_o/zero_o/illegal_o valid.
- result_o  output  WIDTH  operation result; held until next done_o.
- zero_o  output  1  branch flag; held with result_o.
- illegal_o  output  1  high with done_o when ctrl_i was undefined.

Behaviour:
- Reset (async, any state): state=IDLE; busy_o=0, done_o=0, result_o=0, zero_o=0, illegal_o=0; multiplier registers cleared. Any in-flight MUL is abandoned, with no done_o for it.
- States: IDLE, MUL, DONE.
- IDLE, start_i=0: stay in IDLE; done_o=0.
- IDLE, start_i=1, ctrl_i!=1011: compute and register the result, then go to DONE. done_o=1 in the next cycle (latency 1).
- IDLE, start_i=1, ctrl_i=1011: latch A into the multiplicand and B into the multiplier, clear the accumulator and the iteration counter, go to MUL, busy_o=1.
- MUL, each cycle:
  - if multiplier[0]=1, accumulator += multiplicand (mod 2^WIDTH);
  - multiplicand <<= 1; multiplier >>= 1 (logical); counter++.
  - After WIDTH iterations go to DONE with result_o = accumulator and busy_o = 0.
  - done_o rises WIDTH+1 cycles after the start cycle (33 for WIDTH=32).
  - Fixed latency: there is no early exit when the multiplier reaches 0.
- DONE: done_o=1 for exactly one cycle, then IDLE. start_i is ignored in DONE; back-to-back issue therefore needs a 2-cycle spacing.
- start_i during MUL or DONE: ignored, with no queuing. Operand changes after the start cycle have no effect.
- Codes (A=src1, B=src2, all arithmetic mod 2^WIDTH):
  - 0010 ADD: A+B.
  - 0110 SUB: A-B.
  - 0000 AND: A&B.
  - 0001 OR: A|B.
  - 0111 SLT: 1 if signed A<B, else 0.
  - 1000 SRA: B arithmetic-shifted right by shamt_i.
  - 1001 SRAV: B arithmetic-shifted right by A[SHW-1:0].
  - 1011 MUL: low WIDTH bits of A*B. Signed and unsigned give identical low bits.
  - 1100 BNE: A-B.
- zero_o:
  - codes other than 1100: 1 when result==0;
  - code 1100: 1 when result!=0, i.e. branch taken;
  - MUL: computed on the final accumulator.
- Undefined code: result_o=0, zero_o=0, illegal_o=1, latency 1. illegal_o is 0 for all defined codes.
- No overflow flag; ADD/SUB wrap silently.

Test Plan:
- Reset mid-MUL: start MUL 7*9, assert rst_i in cycle 10 -> outputs 0 immediately, no done_o; then ADD 5+3 -> done_o one cycle after start, result_o=8, zero_o=0.
- SUB/BNE/zero: SUB 0x10-0x10 -> result 0, zero_o=1. BNE 4,4 -> result 0, zero_o=0. BNE 4,5 -> result 0xFFFFFFFF, zero_o=1.
- SLT/shift: SLT 0xFFFFFFFF,1 -> 1. SRA B=0x80000000, shamt=4 -> 0xF8000000. SRAV A=0x24, B=0x80000000 -> shift 4, 0xF8000000.
- MUL latency/values: 0x0000FFFF*0x0000FFFF -> 0xFFFE0001 with done_o exactly 33 cycles after start and busy_o high for 32 cycles. 0xFFFFFFFF*3 -> 0xFFFFFFFD. 0*0x12345678 -> 0, zero_o=1.
- Handshake: pulse start_i with ADD every cycle -> only starts sampled in IDLE execute (every 2nd cycle). start_i held during MUL -> ignored, single done_o.
- Illegal code 0101 -> done_o with illegal_o=1, result_o=0. Next legal AND 0xF0F0&0xFF00 -> 0xF000, illegal_o=0.
